// File: rtl/seq_mult_pkg.sv
// Shared constants for the sequential shift-add multiplier.
package seq_mult_pkg;

   // FSM state encoding; 2'b11 is unused and treated as IDLE.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_CALC = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // Largest supported operand width.
   localparam int MAX_WIDTH = 16;

   // Map any raw state code onto a legal state so a corrupted code recovers to IDLE.
   function automatic logic [1:0] legal_state(input logic [1:0] s);
      logic [1:0] r;
      case (s)
         ST_IDLE: r = ST_IDLE;
         ST_CALC: r = ST_CALC;
         ST_DONE: r = ST_DONE;
         default: r = ST_IDLE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_mult_ctrl_rca_n.sv
// Ripple-carry adder built from single-bit full-adder cells.

// Library full-adder cell.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// WIDTH-bit ripple-carry adder: cells chained carry-to-carry, LSB first.
module rca_n #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_cell u_fa (
         .a  (x[i]),
         .b  (y[i]),
         .ci (carry[i]),
         .s  (s[i]),
         .co (carry[i+1])
      );
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier controller: one shared ripple-carry adder
// is reused for WIDTH iterations to produce a 2*WIDTH-bit unsigned product.
// WIDTH is expected to lie in 2..MAX_WIDTH.
module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [1:0]         state_q,   state_d;
   logic [WIDTH-1:0]   m_q,       m_d;
   logic [WIDTH-1:0]   q_q,       q_d;
   logic [WIDTH-1:0]   acc_q,     acc_d;
   logic               c_q,       c_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [WIDTH-1:0]   sum_s;
   logic               cout_s;
   logic [WIDTH-1:0]   add_acc_s;
   logic               add_c_s;
   logic [WIDTH-1:0]   acc_shift_s;
   logic [WIDTH-1:0]   q_shift_s;

   rca_n #(.WIDTH(WIDTH)) u_rca (
      .x    (acc_q),
      .y    (m_q),
      .cin  (1'b0),
      .s    (sum_s),
      .cout (cout_s)
   );

   // Add step: take the adder result when the multiplier LSB is set, else keep ACC.
   always_comb begin
      add_acc_s = acc_q;
      add_c_s   = 1'b0;
      if (q_q[0]) begin
         add_acc_s = sum_s;
         add_c_s   = cout_s;
      end else begin
         add_acc_s = acc_q;
         add_c_s   = 1'b0;
      end
   end

   // Shift step on the post-add value: carry enters the ACC MSB, ACC LSB enters Q.
   always_comb begin
      acc_shift_s = {add_c_s, add_acc_s[WIDTH-1:1]};
      q_shift_s   = {add_acc_s[0], q_q[WIDTH-1:1]};
   end

   // Next-state and datapath register updates for the IDLE/CALC/DONE sequence.
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      q_d       = q_q;
      acc_d     = acc_q;
      c_d       = c_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (legal_state(state_q))
         ST_IDLE: begin
            if (start) begin
               m_d     = a;
               q_d     = b;
               acc_d   = {WIDTH{1'b0}};
               c_d     = 1'b0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            acc_d = acc_shift_s;
            q_d   = q_shift_s;
            c_d   = 1'b0;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               product_d = {acc_shift_s, q_shift_s};
               state_d   = ST_DONE;
            end else begin
               state_d   = ST_CALC;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         m_q       <= {WIDTH{1'b0}};
         q_q       <= {WIDTH{1'b0}};
         acc_q     <= {WIDTH{1'b0}};
         c_q       <= 1'b0;
         cnt_q     <= {CNT_W{1'b0}};
         product_q <= {(2*WIDTH){1'b0}};
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         q_q       <= q_d;
         acc_q     <= acc_d;
         c_q       <= c_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // Status outputs decode the state register only, so start has no combinational path.
   always_comb begin
      busy    = (state_q == ST_CALC) || (state_q == ST_DONE);
      done    = (state_q == ST_DONE);
      product = product_q;
   end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed testbench for seq_mult_ctrl at WIDTH=4 and WIDTH=8.
module tb_seq_mult_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start4, start8;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  product4;
   logic [15:0] product8;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   seq_mult_ctrl #(.WIDTH(4)) dut4 (
      .clk     (clk),
      .rst     (rst),
      .start   (start4),
      .a       (a4),
      .b       (b4),
      .busy    (busy4),
      .done    (done4),
      .product (product4)
   );

   seq_mult_ctrl #(.WIDTH(8)) dut8 (
      .clk     (clk),
      .rst     (rst),
      .start   (start8),
      .a       (a8),
      .b       (b8),
      .busy    (busy8),
      .done    (done8),
      .product (product8)
   );

   // Count one comparison and report it when observed and expected differ.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One WIDTH=4 operation: checks done latency, busy length, done pulse count and product.
   task automatic op4(input string tag, input logic [3:0] aa, input logic [3:0] bb,
                      input logic [7:0] exp);
      int done_at, done_cnt, busy_cnt;
      logic [7:0] prod_at_done;
      done_at = 0; done_cnt = 0; busy_cnt = 0; prod_at_done = 8'd0;
      @(negedge clk);
      a4 = aa; b4 = bb; start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      a4 = ~aa; b4 = ~bb;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (busy4) busy_cnt++;
         if (done4) begin
            done_cnt++;
            if (done_at == 0) begin
               done_at = i;
               prod_at_done = product4;
            end
         end
      end
      // i counts cycles after the accepting edge; done is in the cycle after E_WIDTH
      check({tag, " done_latency"}, done_at, 5);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " busy_cycles"}, busy_cnt, 5);
      check({tag, " product"}, prod_at_done, exp);
      check({tag, " product_hold"}, product4, exp);
   endtask

   // One WIDTH=8 operation: checks the product and that done pulses exactly once.
   task automatic op8(input logic [7:0] aa, input logic [7:0] bb);
      int done_cnt;
      logic [15:0] prod_at_done;
      logic [15:0] exp;
      done_cnt = 0; prod_at_done = 16'hDEAD;
      exp = 16'(aa) * 16'(bb);
      @(negedge clk);
      a8 = aa; b8 = bb; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         if (done8) begin
            done_cnt++;
            prod_at_done = product8;
         end
      end
      check("w8 product", prod_at_done, exp);
      check("w8 done_pulses", done_cnt, 1);
   endtask

   initial begin
      int first_done, second_done;
      logic [7:0] first_prod, second_prod;
      logic [7:0] ra, rb;

      rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
      a4 = 4'd0; b4 = 4'd0; a8 = 8'd0; b8 = 8'd0;
      #12;
      check("reset busy", busy4, 0);
      check("reset done", done4, 0);
      check("reset product", product4, 0);
      check("reset product w8", product8, 0);
      @(negedge clk);
      rst = 1'b0;

      op4("3x5", 4'd3, 4'd5, 8'd15);
      op4("15x15", 4'd15, 4'd15, 8'hE1);
      op4("0x9", 4'd0, 4'd9, 8'd0);
      op4("7x0", 4'd7, 4'd0, 8'd0);
      op4("1x15", 4'd1, 4'd15, 8'd15);
      op4("12x11", 4'd12, 4'd11, 8'd132);

      // start held high; operands changed after the accept must be ignored
      first_done = 0; second_done = 0; first_prod = 8'd0; second_prod = 8'd0;
      @(negedge clk);
      a4 = 4'd2; b4 = 4'd6; start4 = 1'b1;
      @(posedge clk);
      #1 a4 = 4'd1; b4 = 4'd1;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (done4) begin
            if (first_done == 0) begin
               first_done = i;
               first_prod = product4;
            end else if (second_done == 0) begin
               second_done = i;
               second_prod = product4;
            end else begin
               second_done = second_done;
            end
         end
      end
      start4 = 1'b0;
      check("held first_done", first_done, 5);
      check("held first_product", first_prod, 12);
      check("held restart_spacing", second_done - first_done, 6);
      check("held second_product", second_prod, 1);
      for (int i = 0; i < 10; i++) @(negedge clk);
      check("held back_to_idle", busy4, 0);

      // asynchronous reset during CALC
      @(negedge clk);
      a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      check("pre_rst busy", busy4, 1);
      rst = 1'b1;
      #1;
      check("async_rst busy", busy4, 0);
      check("async_rst done", done4, 0);
      check("async_rst product", product4, 0);
      @(negedge clk);
      rst = 1'b0;
      op4("after_rst 4x4", 4'd4, 4'd4, 8'd16);

      // WIDTH=8 corners then pseudo-random pairs against a reference multiply
      op8(8'd0, 8'd0);
      op8(8'd255, 8'd255);
      op8(8'd255, 8'd1);
      op8(8'd128, 8'd2);
      for (int k = 0; k < 1000; k++) begin
         ra = 8'($urandom_range(255, 0));
         rb = 8'($urandom_range(255, 0));
         op8(ra, rb);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
